// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and main-memory signals that meet at
// the memory arbiter. The arbiter takes the slave view; the surrounding system takes the master view.
`timescale 1ns/1ps
interface mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int D_W    = 32,
    parameter int I_W    = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [I_W-1:0]    i_readdata;
    logic              i_busywait;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [D_W-1:0]    d_writedata;
    logic [D_W-1:0]    d_readdata;
    logic              d_busywait;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W:0]   mem_address;
    logic [I_W-1:0]    mem_writedata;
    logic [I_W-1:0]    mem_readdata;
    logic              mem_busywait;

    modport slave (
        input  i_read, i_address,
        output i_readdata, i_busywait,
        input  d_read, d_write, d_address, d_writedata,
        output d_readdata, d_busywait,
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport master (
        output i_read, i_address,
        input  i_readdata, i_busywait,
        output d_read, d_write, d_address, d_writedata,
        input  d_readdata, d_busywait,
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 128-bit main-memory port between instruction-cache
// refills and data-cache refills/write-backs; one transfer in flight, read data registered.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int D_W    = 32,
    parameter int I_W    = 128
) (
    input logic          CLK,
    input logic          RESET,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    state_t         state_q, state_d;
    side_t          last_grant_q, last_grant_d;
    logic           started_q, started_d;
    logic [I_W-1:0] i_readdata_q, i_readdata_d;
    logic [D_W-1:0] d_readdata_q, d_readdata_d;

    logic i_req;
    logic d_req;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // NOTE: every _d signal takes its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        started_d    = started_q;
        i_readdata_d = i_readdata_q;
        d_readdata_d = d_readdata_q;

        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (i_req && (!d_req || last_grant_q == SIDE_D)) begin
                    state_d      = GRANT_I;
                    last_grant_d = SIDE_I;
                end else if (d_req) begin
                    state_d      = GRANT_D;
                    last_grant_d = SIDE_D;
                end
            end

            GRANT_I: begin
                if (!i_req) begin
                    state_d   = IDLE;
                    started_d = 1'b0;
                end else if (!started_q) begin
                    started_d = bus.mem_busywait;
                end else if (!bus.mem_busywait) begin
                    i_readdata_d = bus.mem_readdata;
                    started_d    = 1'b0;
                    state_d      = RESP_I;
                end
            end

            GRANT_D: begin
                if (!d_req) begin
                    state_d   = IDLE;
                    started_d = 1'b0;
                end else if (!started_q) begin
                    started_d = bus.mem_busywait;
                end else if (!bus.mem_busywait) begin
                    if (!bus.d_write) begin
                        d_readdata_d = bus.mem_readdata[D_W-1:0];
                    end
                    started_d = 1'b0;
                    state_d   = RESP_D;
                end
            end

            RESP_I, RESP_D: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                started_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            last_grant_q <= SIDE_D;
            started_q    <= 1'b0;
            i_readdata_q <= '0;
            d_readdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            started_q    <= started_d;
            i_readdata_q <= i_readdata_d;
            d_readdata_q <= d_readdata_d;
        end
    end

    // Memory strobes follow the granted cache's live request, so a withdrawn request drops them at once.
    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writedata = '0;

        case (state_q)
            GRANT_I: begin
                bus.mem_address = {1'b0, bus.i_address};
                bus.mem_read    = bus.i_read;
            end
            GRANT_D: begin
                bus.mem_address   = {1'b1, bus.d_address};
                bus.mem_writedata = {{(I_W-D_W){1'b0}}, bus.d_writedata};
                bus.mem_write     = bus.d_write;
                bus.mem_read      = bus.d_read & ~bus.d_write;
            end
            default: begin
            end
        endcase
    end

    assign bus.i_busywait = RESET & i_req & (state_q != RESP_I);
    assign bus.d_busywait = RESET & d_req & (state_q != RESP_D);
    assign bus.i_readdata = i_readdata_q;
    assign bus.d_readdata = d_readdata_q;
endmodule
